turn_sequencer: RTL and testbench

Move-sequencing controller for the tic-tac-toe game datapath. It debounces the player push-button and validates the 9-bit cell-select switch word against the board. It commits legal moves to the board register and scans the eight win lines one per cycle. It then resolves win, draw or turn hand-over, and drives the board/turn/winner state consumed by the renderer and the seven-segment turn display.

---
 rtl/turn_sequencer.sv | 179 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Tic-tac-toe move sequencer: debounces the commit button, validates and commits
// the selected cell, scans the eight win lines and resolves win/draw/hand-over.
//
// state    | meaning
// IDLE     | waiting for a debounced press during play
// VALIDATE | switches sampled; legal iff one-hot and the cell is empty
// WRITE    | current player's mark written into the latched cell
// CHECK    | one win line tested per cycle, line index 0..7
// RESOLVE  | win, draw or turn hand-over decided from the hit vector
// DONE     | game over; press with switches==0 starts a new game
module turn_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [8:0]  switches,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [7:0]  win_line,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VALIDATE = 3'd1,
        WRITE    = 3'd2,
        CHECK    = 3'd3,
        RESOLVE  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t           state, state_d;
    logic             sync1, sync2, db_level, db_prev, press;
    logic [CNT_W-1:0] db_cnt;
    logic [3:0]       sel_idx, cell_idx;
    logic [3:0]       c0, c1, c2;
    logic [2:0]       line_idx;
    logic [7:0]       hit;
    logic             one_hot, legal, line_hit, full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            press    <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1   <= button;
            sync2   <= sync1;
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel_idx = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (switches[i]) sel_idx = 4'(i);
        end
    end

    assign one_hot = (switches != 9'd0) && ((switches & (switches - 9'd1)) == 9'd0);
    assign legal   = one_hot && (board[{sel_idx, 1'b0} +: 2] == 2'b00);

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board[2*i +: 2] == 2'b00) full = 1'b0;
        end
    end

    // Cell triplets of the eight lines: rows, columns, then both diagonals.
    always_comb begin
        case (line_idx)
            3'd0:    {c0, c1, c2} = {4'd0, 4'd1, 4'd2};
            3'd1:    {c0, c1, c2} = {4'd3, 4'd4, 4'd5};
            3'd2:    {c0, c1, c2} = {4'd6, 4'd7, 4'd8};
            3'd3:    {c0, c1, c2} = {4'd0, 4'd3, 4'd6};
            3'd4:    {c0, c1, c2} = {4'd1, 4'd4, 4'd7};
            3'd5:    {c0, c1, c2} = {4'd2, 4'd5, 4'd8};
            3'd6:    {c0, c1, c2} = {4'd0, 4'd4, 4'd8};
            default: {c0, c1, c2} = {4'd2, 4'd4, 4'd6};
        endcase
    end

    assign line_hit = (board[{c0, 1'b0} +: 2] == turn) &&
                      (board[{c1, 1'b0} +: 2] == turn) &&
                      (board[{c2, 1'b0} +: 2] == turn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (press) state_d = VALIDATE;
            VALIDATE: state_d = legal ? WRITE : IDLE;
            WRITE:    state_d = CHECK;
            CHECK:    if (line_idx == 3'd7) state_d = RESOLVE;
            RESOLVE:  state_d = ((hit != 8'd0) || full) ? DONE : IDLE;
            DONE:     if (press && (switches == 9'd0)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign busy = (state == VALIDATE) || (state == WRITE) ||
                  (state == CHECK)    || (state == RESOLVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board     <= '0;
            turn      <= 2'b01;
            winner    <= 2'b00;
            game_over <= 1'b0;
            win_line  <= 8'd0;
            err       <= 1'b0;
            cell_idx  <= 4'd0;
            line_idx  <= 3'd0;
            hit       <= 8'd0;
        end else begin
            err <= (state == VALIDATE) && !legal;
            case (state)
                VALIDATE: if (legal) cell_idx <= sel_idx;
                WRITE: begin
                    board[{cell_idx, 1'b0} +: 2] <= turn;
                    line_idx <= 3'd0;
                    hit      <= 8'd0;
                end
                CHECK: begin
                    if (line_hit) hit[line_idx] <= 1'b1;
                    line_idx <= line_idx + 3'd1;
                end
                RESOLVE: begin
                    if (hit != 8'd0) begin
                        winner    <= turn;
                        win_line  <= hit;
                        game_over <= 1'b1;
                        turn      <= 2'b00;
                    end else if (full) begin
                        winner    <= 2'b11;
                        win_line  <= 8'd0;
                        game_over <= 1'b1;
                        turn      <= 2'b00;
                    end else begin
                        turn <= (turn == 2'b01) ? 2'b10 : 2'b01;
                    end
                end
                DONE: begin
                    if (press && (switches == 9'd0)) begin
                        board     <= '0;
                        winner    <= 2'b00;
                        win_line  <= 8'd0;
                        game_over <= 1'b0;
                        turn      <= 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed game scenarios plus random play checked
// against a whole-move reference model of the game rules.
module tb_turn_sequencer;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic [8:0]  switches;
    logic [17:0] board;
    logic [1:0]  turn, winner;
    logic        game_over, err, busy;
    logic [7:0]  win_line;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int busy_seen = 0;

    int         m_cell[9];
    logic [1:0] m_turn, m_winner;
    logic [7:0] m_line;
    logic       m_over;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    turn_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .button(button), .switches(switches),
        .board(board), .turn(turn), .winner(winner), .game_over(game_over),
        .win_line(win_line), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err === 1'b1) err_seen++;
        if (busy === 1'b1) busy_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 2'b01; m_winner = 2'b00; m_line = 8'd0; m_over = 1'b0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    // Whole-move effect of one press; exp_busy is how many cycles busy is high.
    task automatic model_move(input logic [8:0] sw, output bit exp_err, output int exp_busy);
        int idx;
        int empties;
        logic [7:0] hits;
        exp_err = 1'b0;
        exp_busy = 0;
        idx = 0;
        for (int i = 0; i < 9; i++) if (sw[i]) idx = i;
        if (m_over) begin
            if (sw == 9'd0) model_reset();
        end else if ($countones(sw) != 1 || m_cell[idx] != 0) begin
            exp_err = 1'b1;
            exp_busy = 1;
        end else begin
            exp_busy = 11;
            m_cell[idx] = int'(m_turn);
            hits = 8'd0;
            for (int l = 0; l < 8; l++)
                if (m_cell[lines[l][0]] == int'(m_turn) && m_cell[lines[l][1]] == int'(m_turn) &&
                    m_cell[lines[l][2]] == int'(m_turn)) hits[l] = 1'b1;
            empties = 0;
            for (int i = 0; i < 9; i++) if (m_cell[i] == 0) empties++;
            if (hits != 8'd0) begin
                m_winner = m_turn; m_line = hits; m_over = 1'b1; m_turn = 2'b00;
            end else if (empties == 0) begin
                m_winner = 2'b11; m_line = 8'd0; m_over = 1'b1; m_turn = 2'b00;
            end else begin
                m_turn = 2'b11 - m_turn;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; button = 1'b0; switches = 9'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    task automatic press(input logic [8:0] sw, input int hold);
        switches = sw;
        button = 1'b1;
        repeat (hold) @(negedge clk);
        button = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic play_move(input logic [8:0] sw, input string tag);
        bit ee;
        int eb, e0, b0;
        model_move(sw, ee, eb);
        e0 = err_seen; b0 = busy_seen;
        press(sw, 12);
        total++; if (board !== model_board()) begin bad++; $display("FAIL %s board got=%h exp=%h", tag, board, model_board()); end
        total++; if (turn !== m_turn) begin bad++; $display("FAIL %s turn got=%b exp=%b", tag, turn, m_turn); end
        total++; if (winner !== m_winner) begin bad++; $display("FAIL %s winner got=%b exp=%b", tag, winner, m_winner); end
        total++; if (win_line !== m_line) begin bad++; $display("FAIL %s win_line got=%h exp=%h", tag, win_line, m_line); end
        total++; if (game_over !== m_over) begin bad++; $display("FAIL %s game_over got=%b exp=%b", tag, game_over, m_over); end
        total++; if (err_seen - e0 != int'(ee)) begin bad++; $display("FAIL %s err_cycles got=%0d exp=%0d", tag, err_seen - e0, ee); end
        total++; if (busy_seen - b0 != eb) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_seen - b0, eb); end
    endtask

    task automatic test_reset();
        rst = 1'b1; button = 1'b0; switches = 9'd0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({board, turn, winner, game_over, win_line, err, busy} !== {18'h0, 2'b01, 2'b00, 1'b0, 8'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset outputs got=%h/%b/%b/%b/%h/%b/%b exp=0/01/00/0/00/0/0",
                     board, turn, winner, game_over, win_line, err, busy);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    task automatic test_legal_move();
        bit ee;
        int eb, n;
        logic [17:0] exp_b;
        logic [1:0] exp_t;
        model_move(9'h010, ee, eb);
        switches = 9'h010;
        button = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL legal busy_start got=%b exp=1", busy); end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            exp_b = (cyc >= 3) ? 18'h00100 : 18'h0;
            exp_t = (cyc >= 12) ? 2'b10 : 2'b01;
            total++; if (busy !== (cyc <= 11)) begin bad++; $display("FAIL legal busy c%0d got=%b exp=%b", cyc, busy, cyc <= 11); end
            total++; if (board !== exp_b) begin bad++; $display("FAIL legal board c%0d got=%h exp=%h", cyc, board, exp_b); end
            total++; if (turn !== exp_t) begin bad++; $display("FAIL legal turn c%0d got=%b exp=%b", cyc, turn, exp_t); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL legal err c%0d got=%b exp=0", cyc, err); end
            if (cyc < 12) @(negedge clk);
        end
        button = 1'b0;
        repeat (14) @(negedge clk);
        total++; if (board !== model_board()) begin bad++; $display("FAIL legal final_board got=%h exp=%h", board, model_board()); end
    endtask

    task automatic test_bounce();
        int b0;
        do_reset();
        b0 = busy_seen;
        button = 1'b1; switches = 9'h010;
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (board !== 18'h0) begin bad++; $display("FAIL bounce board got=%h exp=0", board); end
        total++; if (turn !== 2'b01) begin bad++; $display("FAIL bounce turn got=%b exp=01", turn); end
        total++; if (busy_seen != b0) begin bad++; $display("FAIL bounce busy_cycles got=%0d exp=0", busy_seen - b0); end
        play_move(9'h010, "bounce_hold");
    endtask

    task automatic test_illegal();
        do_reset();
        play_move(9'h003, "ill_two_bits");
        play_move(9'h000, "ill_no_bits");
        play_move(9'h001, "ill_x0");
        play_move(9'h001, "ill_occupied");
        total++; if (board[1:0] !== 2'b01) begin bad++; $display("FAIL ill_cell0 got=%b exp=01", board[1:0]); end
        total++; if (turn !== 2'b10) begin bad++; $display("FAIL ill_turn got=%b exp=10", turn); end
    endtask

    task automatic test_win();
        logic [8:0] seq[5] = '{9'h001, 9'h008, 9'h002, 9'h010, 9'h004};
        do_reset();
        foreach (seq[i]) play_move(seq[i], "win_move");
        total++;
        if ({winner, win_line, game_over, turn} !== {2'b01, 8'h01, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL win_result got=%b/%h/%b/%b exp=01/01/1/00", winner, win_line, game_over, turn);
        end
        play_move(9'h100, "win_ignored");
        play_move(9'h000, "win_restart");
    endtask

    task automatic test_draw();
        logic [8:0] seq[9] = '{9'h001, 9'h002, 9'h004, 9'h010, 9'h008,
                               9'h020, 9'h080, 9'h040, 9'h100};
        do_reset();
        foreach (seq[i]) play_move(seq[i], "draw_move");
        total++;
        if ({winner, win_line, game_over} !== {2'b11, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL draw_result got=%b/%h/%b exp=11/00/1", winner, win_line, game_over);
        end
        play_move(9'h000, "draw_restart");
        total++;
        if ({board, turn, game_over} !== {18'h0, 2'b01, 1'b0}) begin
            bad++;
            $display("FAIL draw_cleared got=%h/%b/%b exp=0/01/0", board, turn, game_over);
        end
    endtask

    task automatic test_reset_mid_check();
        int n;
        do_reset();
        play_move(9'h001, "mid_pre");
        switches = 9'h020;
        button = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid busy_start got=%b exp=1", busy); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        button = 1'b0;
        #1;
        total++;
        if ({board, turn, winner, game_over, win_line, err, busy} !== {18'h0, 2'b01, 2'b00, 1'b0, 8'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset outputs got=%h/%b/%b/%b/%h/%b/%b exp=0/01/00/0/00/0/0",
                     board, turn, winner, game_over, win_line, err, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        play_move(9'h020, "mid_fresh");
        total++; if (board !== 18'h00400) begin bad++; $display("FAIL mid_fresh_board got=%h exp=00400", board); end
    endtask

    task automatic test_random();
        logic [8:0] sw;
        int r, cnt;
        int empt[$];
        do_reset();
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            empt.delete();
            for (int i = 0; i < 9; i++) if (m_cell[i] == 0) empt.push_back(i);
            if (r < 6 && empt.size() > 0 && !m_over) begin
                cnt = $urandom_range(0, empt.size() - 1);
                sw = 9'd1 << empt[cnt];
            end else if (r < 8) begin
                sw = 9'($urandom_range(0, 511));
            end else begin
                sw = 9'd0;
            end
            play_move(sw, "random");
        end
    endtask

    initial begin
        button = 1'b0;
        switches = 9'd0;
        test_reset();
        test_legal_move();
        test_bounce();
        test_illegal();
        test_win();
        test_draw();
        test_reset_mid_check();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
